// File: rtl/lzd_normalizer.sv
// lzd_normalizer: iterative mantissa normalizer fed by a leading-zero detector.
// An operand (mantissa, exponent, LZ count) is accepted in IDLE. The mantissa is
// shifted left by at most STEP bits per cycle until the LZ count is used up,
// while the exponent drops by the same amount. The shift is capped at the
// exponent, so the exponent never underflows below 0. The result is then held
// in DONE until the downstream side takes it.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is high only in IDLE
//   in_mant/exp/lz        unnormalized mantissa, its exponent, LZD count
//   out_valid / out_ready output handshake; out_valid is high only in DONE
//   out_mant/exp          normalized mantissa and adjusted exponent
//   out_zero              input mantissa was zero
//   out_denorm            exponent limited the shift (out_exp = 0)
//   out_err               LZ count inconsistent with the mantissa
//   busy                  FSM is not in IDLE
module lzd_normalizer #(
    parameter int unsigned MANT_W = 32,
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned LZ_W   = 6,
    parameter int unsigned STEP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [LZ_W-1:0]   in_lz,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_denorm,
    output logic              out_err,
    output logic              busy
);

    // Common width for comparing the LZ count against the exponent.
    localparam int unsigned       CmpW    = (EXP_W > LZ_W) ? EXP_W : LZ_W;
    localparam logic [LZ_W-1:0]   StepAmt = LZ_W'(STEP);
    localparam logic [LZ_W-1:0]   MantWL  = LZ_W'(MANT_W);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q;
    logic [MANT_W-1:0]   mant_q;
    logic [EXP_W-1:0]    exp_q;
    logic [LZ_W-1:0]     lz_q;
    logic [LZ_W-1:0]     rem_q;
    logic                zero_q;
    logic                denorm_q;

    logic [LZ_W-1:0]     step_amt;
    logic [LZ_W-1:0]     rem_d;
    logic [CmpW-1:0]     lz_ext;
    logic [CmpW-1:0]     exp_ext;
    logic [CmpW-1:0]     sh_ext;

    always_comb begin
        step_amt = (rem_q < StepAmt) ? rem_q : StepAmt;
        rem_d    = rem_q - step_amt;
        lz_ext   = CmpW'(in_lz);
        exp_ext  = CmpW'(in_exp);
        // Shift is capped at the exponent; the result then fits both widths.
        sh_ext   = (lz_ext <= exp_ext) ? lz_ext : exp_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mant_q   <= '0;
            exp_q    <= '0;
            lz_q     <= '0;
            rem_q    <= '0;
            zero_q   <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        lz_q <= in_lz;
                        // The mantissa itself decides zero; in_lz is not trusted here.
                        if (in_mant == '0) begin
                            mant_q   <= '0;
                            exp_q    <= '0;
                            rem_q    <= '0;
                            zero_q   <= 1'b1;
                            denorm_q <= 1'b0;
                            state_q  <= StDone;
                        end else begin
                            mant_q   <= in_mant;
                            exp_q    <= in_exp - EXP_W'(sh_ext);
                            rem_q    <= LZ_W'(sh_ext);
                            zero_q   <= 1'b0;
                            denorm_q <= (lz_ext > exp_ext);
                            state_q  <= (sh_ext == '0) ? StDone : StShift;
                        end
                    end
                end
                StShift: begin
                    mant_q <= mant_q << step_amt;
                    rem_q  <= rem_d;
                    if (rem_d == '0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gate with rst_n so in_ready stays low while reset is asserted.
    assign in_ready   = (state_q == StIdle) && rst_n;
    assign out_valid  = (state_q == StDone);
    assign busy       = (state_q != StIdle);
    assign out_mant   = mant_q;
    assign out_exp    = exp_q;
    assign out_zero   = zero_q;
    assign out_denorm = denorm_q;
    // Only meaningful once the final mantissa is present.
    assign out_err    = out_valid && !zero_q &&
                        ((!denorm_q && !mant_q[MANT_W-1]) || (lz_q >= MantWL));

endmodule
